reg_rename_file: RTL and testbench

- Architectural integer register file plus rename-tag table, directly downstream of the reorder buffer.
- Consumes the ROB's in-order commit stream (rd, ROB alias, result) and writes architectural values.
- Accepts rename requests from the dispatcher, binding rd to the ROB tail id.
- Serves two combinational source-operand lookups (value, tag) to the dispatcher. Tag 0 means "no dependency, value valid"; ROB entry 0 is never allocated.

---
 rtl/reg_rename_file.sv | 145 ++++++++++++++
 tb/tb_reg_rename_file.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_rename_file.sv
// reg_rename_file
//   Architectural integer register file plus rename-tag table, sitting after
//   the reorder buffer. In-order commits write architectural values. Renames
//   bind a destination register to the ROB tail id. Two combinational source
//   lookups return (value, tag). Tag 0 means the value is ready; ROB id 0 is
//   never allocated.
//
// Ports
//   clk, rst_n          clock (rising edge), async active-low reset
//   rdy                 global enable; low freezes all state
//   rollback            mispredict flush pulse: clears every tag, drops rename
//   commit_*            ROB commit stream (valid, rd, alias, value)
//   rename_*            dispatcher rename request (valid, rd, alias)
//   rs1_id / rs2_id     lookup indices
//   rs1_* / rs2_*       lookup results (value, producer tag)
//   pending_count       registered count of registers holding a nonzero tag
module reg_rename_file #(
    parameter int XLEN  = 32,
    parameter int NREG  = 32,
    parameter int REG_W = 5,
    parameter int ROB_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rdy,
    input  logic             rollback,
    input  logic             commit_valid,
    input  logic [REG_W-1:0] commit_rd,
    input  logic [ROB_W-1:0] commit_alias,
    input  logic [XLEN-1:0]  commit_value,
    input  logic             rename_valid,
    input  logic [REG_W-1:0] rename_rd,
    input  logic [ROB_W-1:0] rename_alias,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    output logic [XLEN-1:0]  rs1_value,
    output logic [ROB_W-1:0] rs1_tag,
    output logic [XLEN-1:0]  rs2_value,
    output logic [ROB_W-1:0] rs2_tag,
    output logic [REG_W:0]   pending_count
);

    logic [XLEN-1:0]  value_q [NREG];
    logic [ROB_W-1:0] tag_q   [NREG];
    logic [XLEN-1:0]  value_d [NREG];
    logic [ROB_W-1:0] tag_d   [NREG];
    logic [REG_W:0]   pending_d;

    logic commit_en;
    logic rename_en;

    assign commit_en = commit_valid && (commit_rd != '0);
    assign rename_en = rename_valid && (rename_rd != '0) && !rollback;

    // Next-state tables. Rename is applied after commit so that a same-cycle
    // commit and rename to one register leaves the new producer's tag.
    always_comb begin
        value_d = value_q;
        tag_d   = tag_q;

        if (commit_en) begin
            value_d[commit_rd] = commit_value;
            // Only the youngest producer may clear the tag; an older commit
            // must not expose a value a younger in-flight op will overwrite.
            if (tag_q[commit_rd] == commit_alias) begin
                tag_d[commit_rd] = '0;
            end
        end

        if (rollback) begin
            for (int i = 0; i < NREG; i++) begin
                tag_d[i] = '0;
            end
        end else if (rename_en) begin
            tag_d[rename_rd] = rename_alias;
        end

        value_d[0] = '0;
        tag_d[0]   = '0;
    end

    always_comb begin
        pending_d = '0;
        for (int i = 1; i < NREG; i++) begin
            if (tag_d[i] != '0) begin
                pending_d = pending_d + (REG_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= '0;
                tag_q[i]   <= '0;
            end
            pending_count <= '0;
        end else if (rdy) begin
            for (int i = 0; i < NREG; i++) begin
                value_q[i] <= value_d[i];
                tag_q[i]   <= tag_d[i];
            end
            pending_count <= pending_d;
        end
    end

    // Lookups see the current table plus a same-cycle commit bypass. The
    // bypass is only taken when the commit will really take effect (rdy high)
    // and it retires the register's current producer. A same-cycle rename is
    // deliberately invisible: sources are read before the rd binding.
    logic fwd1;
    logic fwd2;

    assign fwd1 = rdy && commit_en && (commit_rd == rs1_id) &&
                  (tag_q[rs1_id] == commit_alias);
    assign fwd2 = rdy && commit_en && (commit_rd == rs2_id) &&
                  (tag_q[rs2_id] == commit_alias);

    always_comb begin
        rs1_value = '0;
        rs1_tag   = '0;
        if (rs1_id != '0) begin
            if (fwd1) begin
                rs1_value = commit_value;
            end else begin
                rs1_value = value_q[rs1_id];
                rs1_tag   = tag_q[rs1_id];
            end
        end
    end

    always_comb begin
        rs2_value = '0;
        rs2_tag   = '0;
        if (rs2_id != '0) begin
            if (fwd2) begin
                rs2_value = commit_value;
            end else begin
                rs2_value = value_q[rs2_id];
                rs2_tag   = tag_q[rs2_id];
            end
        end
    end

endmodule

// File: tb/tb_reg_rename_file.sv
module tb_reg_rename_file;

    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic        rollback;
    logic        commit_valid;
    logic [4:0]  commit_rd;
    logic [3:0]  commit_alias;
    logic [31:0] commit_value;
    logic        rename_valid;
    logic [4:0]  rename_rd;
    logic [3:0]  rename_alias;
    logic [4:0]  rs1_id;
    logic [4:0]  rs2_id;
    logic [31:0] rs1_value;
    logic [3:0]  rs1_tag;
    logic [31:0] rs2_value;
    logic [3:0]  rs2_tag;
    logic [5:0]  pending_count;

    int n_cmp = 0;
    int n_err = 0;

    reg_rename_file dut (
        .clk(clk), .rst_n(rst_n), .rdy(rdy), .rollback(rollback),
        .commit_valid(commit_valid), .commit_rd(commit_rd),
        .commit_alias(commit_alias), .commit_value(commit_value),
        .rename_valid(rename_valid), .rename_rd(rename_rd),
        .rename_alias(rename_alias),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_value(rs1_value), .rs1_tag(rs1_tag),
        .rs2_value(rs2_value), .rs2_tag(rs2_tag),
        .pending_count(pending_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle();
        rollback     = 1'b0;
        commit_valid = 1'b0;
        commit_rd    = '0;
        commit_alias = '0;
        commit_value = '0;
        rename_valid = 1'b0;
        rename_rd    = '0;
        rename_alias = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic do_rename(input logic [4:0] rd, input logic [3:0] alias_id);
        rename_valid = 1'b1;
        rename_rd    = rd;
        rename_alias = alias_id;
        tick();
    endtask

    task automatic do_commit(input logic [4:0] rd, input logic [3:0] alias_id,
                             input logic [31:0] val);
        commit_valid = 1'b1;
        commit_rd    = rd;
        commit_alias = alias_id;
        commit_value = val;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy   = 1'b1;
        idle();
        rs1_id = 5'd5;
        rs2_id = 5'd31;
        #3;
        n_cmp++;
        if (rs1_value !== 32'h0 || rs1_tag !== 4'h0) begin
            n_err++;
            $display("FAIL reset_rs1: got %h/%h expected 0/0", rs1_value, rs1_tag);
        end
        n_cmp++;
        if (rs2_value !== 32'h0 || rs2_tag !== 4'h0) begin
            n_err++;
            $display("FAIL reset_rs2: got %h/%h expected 0/0", rs2_value, rs2_tag);
        end
        n_cmp++;
        if (pending_count !== 6'd0) begin
            n_err++;
            $display("FAIL reset_pending: got %0d expected 0", pending_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic test_rename_commit();
        do_rename(5'd5, 4'd3);
        rs1_id = 5'd5;
        #1;
        n_cmp++;
        if (rs1_tag !== 4'd3) begin
            n_err++;
            $display("FAIL rename_x5_tag: got %0d expected 3", rs1_tag);
        end
        n_cmp++;
        if (pending_count !== 6'd1) begin
            n_err++;
            $display("FAIL rename_x5_pending: got %0d expected 1", pending_count);
        end
        do_commit(5'd5, 4'd3, 32'h1234);
        n_cmp++;
        if (rs1_value !== 32'h1234 || rs1_tag !== 4'd0) begin
            n_err++;
            $display("FAIL commit_x5: got %h/%h expected 00001234/0", rs1_value, rs1_tag);
        end
        n_cmp++;
        if (pending_count !== 6'd0) begin
            n_err++;
            $display("FAIL commit_x5_pending: got %0d expected 0", pending_count);
        end
    endtask

    task automatic test_stale_commit();
        rs2_id = 5'd7;
        do_rename(5'd7, 4'd2);
        do_rename(5'd7, 4'd4);
        n_cmp++;
        if (rs2_tag !== 4'd4 || pending_count !== 6'd1) begin
            n_err++;
            $display("FAIL rerename_x7: got tag %0d pend %0d expected 4/1", rs2_tag, pending_count);
        end
        do_commit(5'd7, 4'd2, 32'hAA);
        n_cmp++;
        if (rs2_value !== 32'hAA || rs2_tag !== 4'd4) begin
            n_err++;
            $display("FAIL stale_commit_x7: got %h/%h expected 000000aa/4", rs2_value, rs2_tag);
        end
        n_cmp++;
        if (pending_count !== 6'd1) begin
            n_err++;
            $display("FAIL stale_commit_pending: got %0d expected 1", pending_count);
        end
        do_commit(5'd7, 4'd4, 32'hBB);
        n_cmp++;
        if (rs2_value !== 32'hBB || rs2_tag !== 4'd0 || pending_count !== 6'd0) begin
            n_err++;
            $display("FAIL final_commit_x7: got %h/%h pend %0d expected 000000bb/0/0",
                     rs2_value, rs2_tag, pending_count);
        end
    endtask

    task automatic test_forward();
        do_rename(5'd9, 4'd6);
        commit_valid = 1'b1;
        commit_rd    = 5'd9;
        commit_alias = 4'd6;
        commit_value = 32'h55;
        rename_valid = 1'b1;
        rename_rd    = 5'd9;
        rename_alias = 4'd7;
        rs1_id       = 5'd9;
        rs2_id       = 5'd7;
        #1;
        n_cmp++;
        if (rs1_value !== 32'h55 || rs1_tag !== 4'd0) begin
            n_err++;
            $display("FAIL forward_x9: got %h/%h expected 00000055/0", rs1_value, rs1_tag);
        end
        n_cmp++;
        if (rs2_value !== 32'hBB || rs2_tag !== 4'd0) begin
            n_err++;
            $display("FAIL forward_other_port: got %h/%h expected 000000bb/0", rs2_value, rs2_tag);
        end
        tick();
        n_cmp++;
        if (rs1_value !== 32'h55 || rs1_tag !== 4'd7) begin
            n_err++;
            $display("FAIL commit_rename_x9: got %h/%h expected 00000055/7", rs1_value, rs1_tag);
        end
        n_cmp++;
        if (pending_count !== 6'd1) begin
            n_err++;
            $display("FAIL commit_rename_pending: got %0d expected 1", pending_count);
        end
    endtask

    task automatic test_rollback();
        do_rename(5'd1, 4'd1);
        do_rename(5'd2, 4'd2);
        do_rename(5'd3, 4'd3);
        n_cmp++;
        if (pending_count !== 6'd4) begin
            n_err++;
            $display("FAIL pre_rollback_pending: got %0d expected 4", pending_count);
        end
        rollback     = 1'b1;
        commit_valid = 1'b1;
        commit_rd    = 5'd1;
        commit_alias = 4'd1;
        commit_value = 32'hDEAD;
        rename_valid = 1'b1;
        rename_rd    = 5'd4;
        rename_alias = 4'd5;
        tick();
        rs1_id = 5'd1;
        rs2_id = 5'd4;
        #1;
        n_cmp++;
        if (rs1_value !== 32'hDEAD || rs1_tag !== 4'd0) begin
            n_err++;
            $display("FAIL rollback_x1: got %h/%h expected 0000dead/0", rs1_value, rs1_tag);
        end
        n_cmp++;
        if (rs2_tag !== 4'd0) begin
            n_err++;
            $display("FAIL rollback_x4_tag: got %0d expected 0", rs2_tag);
        end
        rs1_id = 5'd2;
        rs2_id = 5'd9;
        #1;
        n_cmp++;
        if (rs1_tag !== 4'd0 || rs2_tag !== 4'd0) begin
            n_err++;
            $display("FAIL rollback_x2_x9_tags: got %0d/%0d expected 0/0", rs1_tag, rs2_tag);
        end
        n_cmp++;
        if (pending_count !== 6'd0) begin
            n_err++;
            $display("FAIL rollback_pending: got %0d expected 0", pending_count);
        end
    endtask

    task automatic test_x0_and_freeze();
        do_rename(5'd6, 4'd1);
        commit_valid = 1'b1;
        commit_rd    = 5'd0;
        commit_alias = 4'd1;
        commit_value = 32'hFFFF;
        rename_valid = 1'b1;
        rename_rd    = 5'd0;
        rename_alias = 4'd2;
        rs1_id       = 5'd0;
        #1;
        n_cmp++;
        if (rs1_value !== 32'h0 || rs1_tag !== 4'd0) begin
            n_err++;
            $display("FAIL x0_during_write: got %h/%h expected 0/0", rs1_value, rs1_tag);
        end
        tick();
        n_cmp++;
        if (rs1_value !== 32'h0 || rs1_tag !== 4'd0 || pending_count !== 6'd1) begin
            n_err++;
            $display("FAIL x0_after_write: got %h/%h pend %0d expected 0/0/1",
                     rs1_value, rs1_tag, pending_count);
        end
        rdy          = 1'b0;
        commit_valid = 1'b1;
        commit_rd    = 5'd6;
        commit_alias = 4'd1;
        commit_value = 32'h777;
        rename_valid = 1'b1;
        rename_rd    = 5'd3;
        rename_alias = 4'd8;
        tick();
        tick();
        rdy    = 1'b1;
        rs1_id = 5'd6;
        rs2_id = 5'd3;
        #1;
        n_cmp++;
        if (rs1_value !== 32'h0 || rs1_tag !== 4'd1) begin
            n_err++;
            $display("FAIL freeze_x6: got %h/%h expected 0/1", rs1_value, rs1_tag);
        end
        n_cmp++;
        if (rs2_value !== 32'h0 || rs2_tag !== 4'd0 || pending_count !== 6'd1) begin
            n_err++;
            $display("FAIL freeze_x3: got %h/%h pend %0d expected 0/0/1",
                     rs2_value, rs2_tag, pending_count);
        end
    endtask

    task automatic test_async_reset();
        do_rename(5'd10, 4'd9);
        rs1_id = 5'd6;
        rs2_id = 5'd10;
        #1;
        n_cmp++;
        if (rs2_tag !== 4'd9 || pending_count !== 6'd2) begin
            n_err++;
            $display("FAIL pre_reset_state: got tag %0d pend %0d expected 9/2", rs2_tag, pending_count);
        end
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (rs1_value !== 32'h0 || rs1_tag !== 4'd0 || rs2_tag !== 4'd0) begin
            n_err++;
            $display("FAIL async_reset_lookup: got %h/%h tag2 %0d expected 0/0/0",
                     rs1_value, rs1_tag, rs2_tag);
        end
        n_cmp++;
        if (pending_count !== 6'd0) begin
            n_err++;
            $display("FAIL async_reset_pending: got %0d expected 0", pending_count);
        end
        rs1_id = 5'd1;
        #1;
        n_cmp++;
        if (rs1_value !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset_x1: got %h expected 0", rs1_value);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_forward();
        test_rollback();
        test_x0_and_freeze();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
